inst_loader: RTL and testbench

//  Byte-stream program loader that writes the instruction memory over its write port (write/addr/datain).
//  It accepts bytes over a valid/ready handshake, packs each 4-byte group MSB-first into a 32-bit word,
//  and writes the words to consecutive addresses starting at BASE_ADDR. It holds the CPU while loading.
//  It sits between the host/UART byte source and the instruction memory.

---
 rtl/inst_loader.sv | 78 +++++++
 tb/tb_inst_loader.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/inst_loader.sv
// inst_loader: byte-stream loader packing 4 bytes MSB-first into 32-bit words
// written to consecutive instruction memory addresses, holding the CPU meanwhile.
module inst_loader #(
   parameter int ADDR_W    = 16,
   parameter int DEPTH     = 256,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] word_count,
   input  logic              abort,
   input  logic              byte_valid,
   input  logic [7:0]        byte_in,
   output logic              byte_ready,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_datain,
   output logic              busy,
   output logic              cpu_hold,
   output logic              done
);
   typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;
   state_t state, state_n;
   logic [ADDR_W-1:0] addr, words_left;
   logic [1:0] byte_idx;
   logic [31:0] word;
   logic take, last;
   assign byte_ready = state == LOAD;
   assign mem_write  = state == WRITE;
   assign done       = state == DONE;
   assign busy       = byte_ready || mem_write;
   assign cpu_hold   = busy;
   // abort suppresses acceptance so it wins over a simultaneous 4th byte
   assign take = byte_ready && byte_valid && !abort;
   assign last = take && byte_idx == 2'd3;
   always_comb begin
      state_n = state;
      case (state)
         IDLE:  if (start) state_n = (word_count != '0) ? LOAD : DONE;
         LOAD:  state_n = abort ? IDLE : last ? WRITE : LOAD;
         WRITE: state_n = abort ? IDLE : (words_left == ADDR_W'(1)) ? DONE : LOAD;
         DONE:  state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         addr       <= '0;
         words_left <= '0;
         byte_idx   <= '0;
         word       <= '0;
         mem_addr   <= '0;
         mem_datain <= '0;
      end else begin
         state <= state_n;
         if (state == IDLE && start) begin
            addr       <= ADDR_W'(BASE_ADDR);
            words_left <= word_count;
            byte_idx   <= '0;
         end
         if (take) begin
            word     <= {word[23:0], byte_in};
            byte_idx <= byte_idx + 2'd1;
         end
         // write port registers are loaded one edge early so WRITE drives them directly
         if (last) begin
            mem_addr   <= addr;
            mem_datain <= {word[23:0], byte_in};
         end
         if (state == WRITE) begin
            addr       <= (addr == ADDR_W'(DEPTH - 1)) ? '0 : addr + ADDR_W'(1);
            words_left <= words_left - ADDR_W'(1);
            byte_idx   <= '0;
         end
      end
   end
endmodule

// File: tb/tb_inst_loader.sv
// tb_inst_loader: table-driven directed vectors for two loaders (BASE_ADDR 0 and 255)
// sharing one stimulus, plus hand-written asynchronous reset sequences.
module tb_inst_loader;
   logic clk = 0, reset = 1, start = 0, abort = 0, byte_valid = 0;
   logic [15:0] word_count = 0;
   logic [7:0] byte_in = 0;
   logic byte_ready0, mem_write0, busy0, cpu_hold0, done0;
   logic byte_ready1, mem_write1, busy1, cpu_hold1, done1;
   logic [15:0] mem_addr0, mem_addr1;
   logic [31:0] mem_datain0, mem_datain1;
   logic [105:0] all_o;
   int n_vec = 0, n_bad = 0;

   always #5 clk = ~clk;

   inst_loader #(.ADDR_W(16), .DEPTH(256), .BASE_ADDR(0)) dut0 (
      .clk(clk), .reset(reset), .start(start), .word_count(word_count), .abort(abort),
      .byte_valid(byte_valid), .byte_in(byte_in), .byte_ready(byte_ready0), .mem_write(mem_write0),
      .mem_addr(mem_addr0), .mem_datain(mem_datain0), .busy(busy0), .cpu_hold(cpu_hold0), .done(done0));
   inst_loader #(.ADDR_W(16), .DEPTH(256), .BASE_ADDR(255)) dut1 (
      .clk(clk), .reset(reset), .start(start), .word_count(word_count), .abort(abort),
      .byte_valid(byte_valid), .byte_in(byte_in), .byte_ready(byte_ready1), .mem_write(mem_write1),
      .mem_addr(mem_addr1), .mem_datain(mem_datain1), .busy(busy1), .cpu_hold(cpu_hold1), .done(done1));

   assign all_o = {busy0, cpu_hold0, byte_ready0, mem_write0, done0, mem_addr0, mem_datain0,
                   busy1, cpu_hold1, byte_ready1, mem_write1, done1, mem_addr1, mem_datain1};

   // o = {busy, byte_ready, mem_write, done}
   localparam logic [3:0] OI = 4'b0000, OL = 4'b1100, OW = 4'b1010, OD = 4'b0001;

   typedef struct {
      string       tag;
      logic        st;
      logic [15:0] wc;
      logic        ab;
      logic        bv;
      logic [7:0]  b;
      logic [3:0]  o;
      logic [15:0] a0, a1;
      logic [31:0] d;
   } vec_t;
   vec_t tbl[$];

   function automatic void add(string tag, logic st, logic [15:0] wc, logic ab, logic bv,
                               logic [7:0] b, logic [3:0] o, logic [15:0] a0 = 0,
                               logic [15:0] a1 = 0, logic [31:0] d = 0);
      vec_t v;
      v.tag = tag; v.st = st; v.wc = wc; v.ab = ab; v.bv = bv; v.b = b;
      v.o = o; v.a0 = a0; v.a1 = a1; v.d = d;
      tbl.push_back(v);
   endfunction

   function automatic void word4(string tag, logic [31:0] w);
      logic [31:0] t;
      t = w;
      for (int k = 3; k >= 0; k--) add(tag, 0, 0, 0, 1, t[k*8 +: 8], OL);
   endfunction

   task automatic chk(string nm, logic [105:0] got, logic [105:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, got, exp);
      end
   endtask

   task automatic apply(vec_t v, int i);
      logic [4:0] e, g0, g1;
      logic ok;
      start = v.st; word_count = v.wc; abort = v.ab; byte_valid = v.bv; byte_in = v.b;
      #1;
      e  = {v.o[3], v.o[3], v.o[2], v.o[1], v.o[0]};
      g0 = {busy0, cpu_hold0, byte_ready0, mem_write0, done0};
      g1 = {busy1, cpu_hold1, byte_ready1, mem_write1, done1};
      ok = (g0 === e) && (g1 === e);
      if (v.o[1]) ok = ok && mem_addr0 === v.a0 && mem_addr1 === v.a1 &&
                       mem_datain0 === v.d && mem_datain1 === v.d;
      n_vec++;
      if (!ok) begin
         n_bad++;
         $display("FAIL %s[%0d]: got ctl %b/%b addr %h/%h data %h/%h, want ctl %b addr %h/%h data %h",
                  v.tag, i, g0, g1, mem_addr0, mem_addr1, mem_datain0, mem_datain1, e, v.a0, v.a1, v.d);
      end
   endtask

   initial begin
      // back-to-back two-word load; dut1 wraps 255 -> 0
      add("t1", 1, 2, 0, 0, 0, OI);
      word4("t1", 32'h12345678);
      add("t1", 0, 0, 0, 0, 0, OW, 0, 255, 32'h12345678);
      word4("t1", 32'h9ABCDEF0);
      add("t1", 0, 0, 0, 0, 0, OW, 1, 0, 32'h9ABCDEF0);
      add("t1", 0, 0, 0, 0, 0, OD);
      add("t1", 0, 0, 0, 0, 0, OI);
      // bursty valid; a byte offered during WRITE must not be consumed
      add("t2", 1, 2, 0, 0, 0, OI);
      add("t2", 0, 0, 0, 1, 8'h12, OL); add("t2", 0, 0, 0, 0, 8'hEE, OL);
      add("t2", 0, 0, 0, 1, 8'h34, OL); add("t2", 0, 0, 0, 0, 8'hEE, OL);
      add("t2", 0, 0, 0, 1, 8'h56, OL); add("t2", 0, 0, 0, 0, 8'hEE, OL);
      add("t2", 0, 0, 0, 1, 8'h78, OL);
      add("t2", 0, 0, 0, 1, 8'hEE, OW, 0, 255, 32'h12345678);
      add("t2", 0, 0, 0, 1, 8'h9A, OL); add("t2", 0, 0, 0, 0, 8'hEE, OL);
      add("t2", 0, 0, 0, 1, 8'hBC, OL); add("t2", 0, 0, 0, 0, 8'hEE, OL);
      add("t2", 0, 0, 0, 1, 8'hDE, OL); add("t2", 0, 0, 0, 0, 8'hEE, OL);
      add("t2", 0, 0, 0, 1, 8'hF0, OL);
      add("t2", 0, 0, 0, 1, 8'hEE, OW, 1, 0, 32'h9ABCDEF0);
      add("t2", 0, 0, 0, 0, 0, OD);
      add("t2", 0, 0, 0, 0, 0, OI);
      // zero-word load
      add("t3", 1, 0, 0, 0, 0, OI);
      add("t3", 0, 0, 0, 0, 0, OD);
      add("t3", 0, 0, 0, 0, 0, OI);
      // abort after two bytes, abort vs 4th byte, then a clean reload
      add("t4", 1, 1, 0, 0, 0, OI);
      add("t4", 0, 0, 0, 1, 8'h11, OL);
      add("t4", 0, 0, 0, 1, 8'h22, OL);
      add("t4", 0, 0, 1, 0, 0, OL);
      add("t4", 0, 0, 0, 0, 0, OI);
      add("t4b", 1, 1, 0, 0, 0, OI);
      add("t4b", 0, 0, 0, 1, 8'hAA, OL);
      add("t4b", 0, 0, 0, 1, 8'hBB, OL);
      add("t4b", 0, 0, 0, 1, 8'hCC, OL);
      add("t4b", 0, 0, 1, 1, 8'hDD, OL);
      add("t4b", 0, 0, 0, 0, 0, OI);
      add("t4c", 1, 1, 0, 0, 0, OI);
      word4("t4c", 32'hAABBCCDD);
      add("t4c", 0, 0, 0, 0, 0, OW, 0, 255, 32'hAABBCCDD);
      add("t4c", 0, 0, 0, 0, 0, OD);
      add("t4c", 0, 0, 0, 0, 0, OI);
      // abort during WRITE: write completes, no second word, no done
      add("t4d", 1, 2, 0, 0, 0, OI);
      word4("t4d", 32'h01020304);
      add("t4d", 0, 0, 1, 0, 0, OW, 0, 255, 32'h01020304);
      add("t4d", 0, 0, 0, 0, 0, OI);
      add("t4d", 0, 0, 0, 0, 0, OI);
      // abort in IDLE/DONE is ignored
      add("t4e", 1, 0, 1, 0, 0, OI);
      add("t4e", 0, 0, 1, 0, 0, OD);
      add("t4e", 0, 0, 0, 0, 0, OI);

      #1 chk("reset_state", all_o, '0);
      @(negedge clk);
      reset = 0;
      foreach (tbl[i]) begin
         apply(tbl[i], i);
         @(negedge clk);
      end

      // async reset mid-LOAD
      start = 1; word_count = 3; abort = 0; byte_valid = 0;
      @(negedge clk);
      start = 0; byte_valid = 1; byte_in = 8'h55;
      #1 chk("pre_rst_load", 106'({busy0, byte_ready0, busy1, byte_ready1}), 106'(4'b1111));
      reset = 1;
      #1 chk("rst_mid_load", all_o, '0);
      @(negedge clk);
      reset = 0; byte_valid = 0;
      #1 chk("rst_release_idle", all_o, '0);
      @(negedge clk);
      start = 1; word_count = 1;
      #1 chk("idle_before_start", all_o, '0);
      @(negedge clk);
      start = 0;
      #1 chk("load_after_rst", 106'({busy0, byte_ready0, busy1, byte_ready1}), 106'(4'b1111));
      // async reset mid-WRITE
      for (int k = 0; k < 4; k++) begin
         byte_valid = 1; byte_in = 8'h60 + 8'(k);
         @(negedge clk);
      end
      byte_valid = 0;
      #1 chk("pre_rst_write", 106'({mem_write0, mem_write1, mem_datain0}), 106'({2'b11, 32'h60616263}));
      reset = 1;
      #1 chk("rst_mid_write", all_o, '0);
      @(negedge clk);
      reset = 0;
      #1 chk("rst_write_release", all_o, '0);
      @(negedge clk);
      #1 chk("rst_write_idle", all_o, '0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
